// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between pc_sequencer (master) and the fetch/datapath side (slave).
interface pc_sequencer_if;
    localparam int unsigned PC_W    = 4;
    localparam int unsigned STAGE_W = 3;
    localparam int unsigned RET_W   = 8;

    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_target;
    logic               halt_req;
    logic               stall;
    logic [PC_W-1:0]    pc_output;
    logic [STAGE_W-1:0] stage;
    logic               halted;
    logic               pc_error;
    logic [RET_W-1:0]   retired;

    modport master (
        input  redirect_valid, redirect_target, halt_req, stall,
        output pc_output, stage, halted, pc_error, retired
    );

    modport slave (
        output redirect_valid, redirect_target, halt_req, stall,
        input  pc_output, stage, halted, pc_error, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// Five-stage multicycle PC/stage sequencer with redirect, halt, range check and retire count.
// Optional hold-on-stall behaviour is enabled by defining PC_SEQ_STALL_EN.
module pc_sequencer #(
    parameter int unsigned MEM_DEPTH = 11,
    parameter int unsigned START_PC  = 0
) (
    input  logic           clock,
    input  logic           reset,
    pc_sequencer_if.master bus
);
    localparam int unsigned PC_W    = 4;
    localparam int unsigned STAGE_W = 3;
    localparam int unsigned RET_W   = 8;

    localparam logic [STAGE_W-1:0] STG_FETCH = STAGE_W'(0);
    localparam logic [STAGE_W-1:0] STG_EX    = STAGE_W'(2);
    localparam logic [STAGE_W-1:0] STG_WB    = STAGE_W'(4);
    localparam logic [STAGE_W-1:0] STG_HALT  = STAGE_W'(7);
    localparam logic [RET_W-1:0]   RET_MAX   = {RET_W{1'b1}};
    localparam logic [PC_W:0]      PC_LIMIT  = (PC_W+1)'(MEM_DEPTH);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [STAGE_W-1:0] r_stage,      w_stage_nxt;
    logic [PC_W-1:0]    r_pc,         w_pc_nxt;
    logic               r_redir_pend, w_redir_pend_nxt;
    logic [PC_W-1:0]    r_redir_tgt,  w_redir_tgt_nxt;
    logic               r_halt_pend,  w_halt_pend_nxt;
    logic               r_halted,     w_halted_nxt;
    logic               r_pc_error,   w_pc_error_nxt;
    logic [RET_W-1:0]   r_retired,    w_retired_nxt;

    logic               w_hold;
    logic               w_advance;
    logic               w_wb_edge;
    logic               w_halt_now;
    logic [PC_W-1:0]    w_next_pc;
    logic               w_pc_oob;

`ifdef PC_SEQ_STALL_EN
    assign w_hold = bus.stall;
`else
    logic w_stall_unused;
    assign w_stall_unused = bus.stall;
    assign w_hold         = 1'b0;
`endif

    // Instruction-boundary decode shared by next-state and output logic
    assign w_advance  = (r_state == S_RUN) && !w_hold;
    assign w_wb_edge  = w_advance && (r_stage == STG_WB);
    assign w_halt_now = r_halt_pend || bus.halt_req;
    assign w_next_pc  = r_redir_pend ? r_redir_tgt : r_pc + PC_W'(1);
    assign w_pc_oob   = {1'b0, w_next_pc} >= PC_LIMIT;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: HALTED is absorbing, entered only at a writeback edge
    always_comb begin
        w_state_nxt = r_state;
        if (w_wb_edge && (w_pc_oob || w_halt_now)) begin
            w_state_nxt = S_HALTED;
        end
    end

    // Output/datapath next values
    always_comb begin
        w_stage_nxt      = r_stage;
        w_pc_nxt         = r_pc;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_tgt_nxt  = r_redir_tgt;
        w_halt_pend_nxt  = r_halt_pend;
        w_halted_nxt     = r_halted;
        w_pc_error_nxt   = r_pc_error;
        w_retired_nxt    = r_retired;

        if (r_state == S_RUN) begin
            // Requests are captured even while the stage is held
            if (bus.halt_req) begin
                w_halt_pend_nxt = 1'b1;
            end
            if ((r_stage == STG_EX) && bus.redirect_valid) begin
                w_redir_pend_nxt = 1'b1;
                w_redir_tgt_nxt  = bus.redirect_target;
            end

            if (w_advance) begin
                if (r_stage == STG_WB) begin
                    w_retired_nxt    = (r_retired == RET_MAX) ? r_retired
                                                              : r_retired + RET_W'(1);
                    w_redir_pend_nxt = 1'b0;
                    w_halt_pend_nxt  = 1'b0;
                    w_stage_nxt      = STG_FETCH;
                    if (w_pc_oob) begin
                        // PC keeps the last legal value
                        w_pc_error_nxt = 1'b1;
                        w_halted_nxt   = 1'b1;
                        w_stage_nxt    = STG_HALT;
                    end else begin
                        w_pc_nxt = w_next_pc;
                        if (w_halt_now) begin
                            w_halted_nxt = 1'b1;
                            w_stage_nxt  = STG_HALT;
                        end
                    end
                end else begin
                    w_stage_nxt = r_stage + STAGE_W'(1);
                end
            end
        end
    end

    // Output/datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stage      <= STG_FETCH;
            r_pc         <= PC_W'(START_PC);
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= '0;
            r_halt_pend  <= 1'b0;
            r_halted     <= 1'b0;
            r_pc_error   <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_stage      <= w_stage_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_tgt  <= w_redir_tgt_nxt;
            r_halt_pend  <= w_halt_pend_nxt;
            r_halted     <= w_halted_nxt;
            r_pc_error   <= w_pc_error_nxt;
            r_retired    <= w_retired_nxt;
        end
    end

    assign bus.pc_output = r_pc;
    assign bus.stage     = r_stage;
    assign bus.halted    = r_halted;
    assign bus.pc_error  = r_pc_error;
    assign bus.retired   = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (MEM_DEPTH=11, START_PC=0).
module tb_pc_sequencer;
    typedef struct packed {
        logic [2:0] stage;
        logic [3:0] pc;
        logic       halted;
        logic       err;
        logic [7:0] ret;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    obs_t sb[$];

    pc_sequencer_if bus ();

    pc_sequencer #(
        .MEM_DEPTH (11),
        .START_PC  (0)
    ) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [2:0] st, input logic [3:0] pc,
                                input logic h, input logic e, input logic [7:0] r);
        obs_t o;
        o.stage  = st;
        o.pc     = pc;
        o.halted = h;
        o.err    = e;
        o.ret    = r;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 4'd0;
        bus.halt_req        = 1'b0;
        bus.stall           = 1'b0;
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic check(input string tag);
        obs_t got;
        obs_t exp;
        got = mk(bus.stage, bus.pc_output, bus.halted, bus.pc_error, bus.retired);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got stage=%0d pc=%0d", tag, got.stage, got.pc);
        end else begin
            exp = sb.pop_front();
            assert (got === exp) else begin
                failures++;
                $error("FAIL %s: got stage=%0d pc=%0d halted=%0b pc_error=%0b retired=%0d, expected stage=%0d pc=%0d halted=%0b pc_error=%0b retired=%0d",
                       tag, got.stage, got.pc, got.halted, got.err, got.ret,
                       exp.stage, exp.pc, exp.halted, exp.err, exp.ret);
            end
        end
    endtask

    task automatic step(input obs_t e, input string tag);
        sb.push_back(e);
        tick();
        check(tag);
    endtask

    // Assert reset off-edge, check the asynchronous clear, hold over one edge, release
    task automatic do_reset(input string tag);
        clear_inputs();
        rst = 1'b1;
        sb.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0, 8'd0));
        #1;
        check({tag, "_async"});
        sb.push_back(mk(3'd0, 4'd0, 1'b0, 1'b0, 8'd0));
        tick();
        check({tag, "_hold"});
        rst = 1'b0;
    endtask

    // One instruction from its stage 0; rv_st/hr_st select the stage carrying each pulse (-1 = none)
    task automatic run_instr(input logic [3:0] pc, input logic [7:0] ret,
                             input int rv_st, input logic [3:0] tgt, input int hr_st,
                             input obs_t fin, input string tag);
        for (int s = 0; s < 5; s++) begin
            bus.redirect_valid  = (s == rv_st);
            bus.redirect_target = tgt;
            bus.halt_req        = (s == hr_st);
            if (s < 4) sb.push_back(mk(3'(s + 1), pc, 1'b0, 1'b0, ret));
            else       sb.push_back(fin);
            tick();
            check($sformatf("%s_pc%0d_s%0d", tag, pc, s));
        end
        clear_inputs();
    endtask

    task automatic hold_halted(input obs_t e, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.redirect_valid  = 1'($urandom_range(0, 1));
            bus.redirect_target = 4'($urandom_range(0, 15));
            bus.halt_req        = 1'($urandom_range(0, 1));
            bus.stall           = 1'($urandom_range(0, 1));
            step(e, $sformatf("%s_%0d", tag, i));
        end
        clear_inputs();
    endtask

    function automatic obs_t run_o(input logic [3:0] pc, input logic [7:0] r);
        return mk(3'd0, pc, 1'b0, 1'b0, r);
    endfunction

    function automatic obs_t halt_o(input logic [3:0] pc, input logic e, input logic [7:0] r);
        return mk(3'd7, pc, 1'b1, e, r);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pc_e;
        clear_inputs();
        #2;

        // Plain sequential run: three instructions
        do_reset("rst_a");
        for (int i = 0; i < 3; i++)
            run_instr(4'(i), 8'(i), -1, 4'd0, -1, run_o(4'(i + 1), 8'(i + 1)), "seq");

        // Redirect outside stage 2 ignored, in stage 2 taken, then redirect+halt together
        run_instr(4'd3, 8'd3, 3, 4'd9, -1, run_o(4'd4, 8'd4), "redir_late");
        run_instr(4'd4, 8'd4, 2, 4'd7, -1, run_o(4'd7, 8'd5), "redir_ex");
        run_instr(4'd7, 8'd5, 2, 4'd2, 2, halt_o(4'd2, 1'b0, 8'd6), "redir_halt");
        hold_halted(halt_o(4'd2, 1'b0, 8'd6), 4, "halted_b");

        // Halt request early in PC 4
        do_reset("rst_c");
        for (int i = 0; i < 4; i++)
            run_instr(4'(i), 8'(i), -1, 4'd0, -1, run_o(4'(i + 1), 8'(i + 1)), "pre_halt");
        run_instr(4'd4, 8'd4, -1, 4'd0, 1, halt_o(4'd5, 1'b0, 8'd5), "halt_s1");
        hold_halted(halt_o(4'd5, 1'b0, 8'd5), 4, "halted_c");

        // Reset asserted asynchronously in stage 3 of PC 6
        do_reset("rst_d");
        for (int i = 0; i < 6; i++)
            run_instr(4'(i), 8'(i), -1, 4'd0, -1, run_o(4'(i + 1), 8'(i + 1)), "pre_abort");
        step(mk(3'd1, 4'd6, 1'b0, 1'b0, 8'd6), "abort_s1");
        step(mk(3'd2, 4'd6, 1'b0, 1'b0, 8'd6), "abort_s2");
        step(mk(3'd3, 4'd6, 1'b0, 1'b0, 8'd6), "abort_s3");
        #2;
        do_reset("rst_mid");
        step(mk(3'd1, 4'd0, 1'b0, 1'b0, 8'd0), "after_abort");

        // Stall in stage 2 with a redirect arriving mid-stall
        do_reset("rst_e");
        step(mk(3'd1, 4'd0, 1'b0, 1'b0, 8'd0), "stall_s1");
        step(mk(3'd2, 4'd0, 1'b0, 1'b0, 8'd0), "stall_s2");
`ifdef PC_SEQ_STALL_EN
        bus.stall = 1'b1;
        step(mk(3'd2, 4'd0, 1'b0, 1'b0, 8'd0), "stall_hold1");
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 4'd9;
        step(mk(3'd2, 4'd0, 1'b0, 1'b0, 8'd0), "stall_hold2");
        bus.redirect_valid = 1'b0;
        step(mk(3'd2, 4'd0, 1'b0, 1'b0, 8'd0), "stall_hold3");
        bus.stall = 1'b0;
        step(mk(3'd3, 4'd0, 1'b0, 1'b0, 8'd0), "stall_s3");
        step(mk(3'd4, 4'd0, 1'b0, 1'b0, 8'd0), "stall_s4");
        step(run_o(4'd9, 8'd1), "stall_next");
        pc_e = 4'd9;
`else
        bus.stall = 1'b1;
        step(mk(3'd3, 4'd0, 1'b0, 1'b0, 8'd0), "nostall_s3");
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 4'd9;
        step(mk(3'd4, 4'd0, 1'b0, 1'b0, 8'd0), "nostall_s4");
        bus.redirect_valid = 1'b0;
        step(run_o(4'd1, 8'd1), "nostall_next");
        pc_e = 4'd1;
`endif
        clear_inputs();

        // Redirect to an out-of-range target: PC holds, sticky error
        run_instr(pc_e, 8'd1, 2, 4'd12, -1, halt_o(pc_e, 1'b1, 8'd2), "oob_redir");
        hold_halted(halt_o(pc_e, 1'b1, 8'd2), 3, "halted_f");

        // Sequential run off the end of memory
        do_reset("rst_g");
        for (int i = 0; i < 10; i++)
            run_instr(4'(i), 8'(i), -1, 4'd0, -1, run_o(4'(i + 1), 8'(i + 1)), "full");
        run_instr(4'd10, 8'd10, -1, 4'd0, -1, halt_o(4'd10, 1'b1, 8'd11), "full_end");
        hold_halted(halt_o(4'd10, 1'b1, 8'd11), 5, "halted_g");

        // Retire counter saturation via a self-loop on PC 0
        do_reset("rst_h");
        for (int k = 0; k < 260; k++)
            run_instr(4'd0, 8'((k > 255) ? 255 : k), 2, 4'd0, -1,
                      run_o(4'd0, 8'((k + 1 > 255) ? 255 : k + 1)), $sformatf("sat%0d", k));

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain: got %0d leftover entries, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
